encoder_profile_sequencer: RTL and testbench
============================================

// Module: encoder_profile_sequencer
// PURPOSE
// AXI-Lite master that plays a table of motion segments into the encoder emulator's control port.
// Each segment is {period, signed step count}: write PERIOD, write STEPS, write CTRL=GO, then poll STATUS until idle.
// Optionally loops the table. Sits between host/test logic and the emulator's CP slave port, so the emulator runs profiles with no CPU involvement.
// PARAMETERS
// DEPTH       8      segment table entries (power of 2, >=2)
// ADDR_W      8      AXI-Lite address width
// REG_PERIOD  8'h00  emulator period register (clk cycles per quadrature edge)
// REG_STEPS   8'h08  emulator signed step-count register
// REG_CTRL    8'h10  emulator control: 64'h1=GO, 64'h0=STOP
// REG_STATUS  8'h18  emulator status; bit BUSY_BIT=1 while segment runs
// BUSY_BIT    0      busy bit index in STATUS
// POLL_GAP    16     idle clk cycles between STATUS reads (>=1)
// PORTS
// clk        in   1          system clock
// reset      in   1          asynchronous, active-low reset
// cmd_valid  in   1          segment write request
// cmd_ready  out  1          = (state==IDLE) && (count<DEPTH)
// cmd_data   in   64         [63:32] period (unsigned), [31:0] steps (signed)
// start      in   1          pulse: run table from entry 0
// abort      in   1          pulse: stop run; in IDLE clears the table
// loop_en    in   1          1 = wrap to entry 0 after last entry (sampled in NEXT)
// busy       out  1          1 in every state except IDLE
// seq_done   out  1          1-cycle pulse on normal completion
// bus_error  out  1          sticky; set on BRESP/RRESP!=0; cleared by start
// cur_idx    out  log2(DEPTH) index of segment in progress
// M_AW{ADDR,VALID,READY}    out,out,in  ADDR_W,1,1
// M_W{DATA,STRB,VALID,READY} out,out,out,in  64,8,1,1  (WSTRB fixed 8'hFF)
// M_B{RESP,VALID,READY}     in,in,out   2,1,1
// M_AR{ADDR,VALID,READY}    out,out,in  ADDR_W,1,1
// M_R{DATA,RESP,VALID,READY} in,in,in,out  64,2,1,1; M_AWPROT/M_ARPROT out 3 = 3'b000
// BEHAVIOUR
// Reset: all VALIDs 0, BREADY/RREADY 0, busy 0, seq_done 0, bus_error 0, count 0, cur_idx 0, state IDLE.
// Table: cmd_valid&&cmd_ready stores cmd_data at [count], count++. abort in IDLE sets count=0 (abort beats start if same cycle).
// start in IDLE, count>0: clear bus_error, cur_idx=0, -> WR_PERIOD next cycle. start with count==0 ignored.
// States: IDLE, WR_PERIOD, WR_STEPS, WR_GO, POLL_WAIT, POLL_RD, NEXT, WR_STOP.
// Write FSM states: AWVALID and WVALID rise together 1 cycle after entry; each drops independently after its own handshake;
//   VALID never deasserted before handshake; BREADY=1 in write states; advance on BVALID.
// WDATA: PERIOD = zero-extended period; STEPS = sign-extended steps; GO = 64'h1; STOP = 64'h0.
// Entry with steps==0: WR_PERIOD skipped straight to NEXT (no bus traffic).
// POLL_WAIT: count POLL_GAP cycles, then POLL_RD: ARVALID until ARREADY, RREADY=1, on RVALID:
//   RDATA[BUSY_BIT]=1 -> POLL_WAIT; =0 -> NEXT.
// NEXT (1 cycle): cur_idx<count-1 -> cur_idx++, WR_PERIOD; else loop_en -> cur_idx=0, WR_PERIOD; else seq_done=1, IDLE.
// Error: BRESP or RRESP !=0 -> bus_error=1, -> WR_STOP (STOP write ignores its own BRESP), then IDLE, no seq_done.
// abort while busy: latched; outstanding transaction completes; then WR_STOP, IDLE; no seq_done. abort in WR_STOP no effect.
// Table is read-only while busy (cmd_ready=0). Reset mid-transaction drops all VALIDs immediately.
// TESTING
// Load {100,+5},{50,-3}, start, slave always ready -> writes 00=100,08=5,10=1, polls, 00=50,08=-3 (64'hFFFF_FFFF_FFFF_FFFD),10=1; seq_done once.
// STATUS busy for 3 reads then 0 -> exactly 4 AR handshakes per segment, reads spaced >=POLL_GAP cycles.
// AWREADY delayed 5 cycles vs WREADY 0 -> AWVALID held stable 5 cycles, single B accepted, no duplicate W.
// BRESP=2'b10 on STEPS write -> bus_error=1, next write is 10=0, busy falls, no seq_done; next start clears bus_error.
// loop_en=1, 2 entries -> cur_idx 0,1,0,1...; abort mid-POLL_RD -> R completes, STOP written, IDLE.
// Load DEPTH entries -> cmd_ready=0; one entry steps=0 -> no writes for it; abort in IDLE -> count=0, start ignored.

Source files
------------

// File: rtl/encoder_profile_sequencer.sv
// AXI-Lite master that replays a table of {period, steps} segments into the encoder emulator
// control port: PERIOD, STEPS, CTRL=GO writes, then STATUS polling until the segment finishes.
module encoder_profile_sequencer #(
    parameter int                DEPTH      = 8,
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] REG_PERIOD = 'h00,
    parameter logic [ADDR_W-1:0] REG_STEPS  = 'h08,
    parameter logic [ADDR_W-1:0] REG_CTRL   = 'h10,
    parameter logic [ADDR_W-1:0] REG_STATUS = 'h18,
    parameter int                BUSY_BIT   = 0,
    parameter int                POLL_GAP   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [63:0]                cmd_data,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       loop_en,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       bus_error,
    output logic [$clog2(DEPTH)-1:0]   cur_idx,
    output logic [ADDR_W-1:0]          M_AWADDR,
    output logic                       M_AWVALID,
    input  logic                       M_AWREADY,
    output logic [2:0]                 M_AWPROT,
    output logic [63:0]                M_WDATA,
    output logic [7:0]                 M_WSTRB,
    output logic                       M_WVALID,
    input  logic                       M_WREADY,
    input  logic [1:0]                 M_BRESP,
    input  logic                       M_BVALID,
    output logic                       M_BREADY,
    output logic [ADDR_W-1:0]          M_ARADDR,
    output logic                       M_ARVALID,
    input  logic                       M_ARREADY,
    output logic [2:0]                 M_ARPROT,
    input  logic [63:0]                M_RDATA,
    input  logic [1:0]                 M_RRESP,
    input  logic                       M_RVALID,
    output logic                       M_RREADY
);
    // state     | meaning
    // IDLE      | table editable, waiting for start
    // WR_PERIOD | write period register (skipped when steps==0)
    // WR_STEPS  | write signed step count
    // WR_GO     | write CTRL=GO
    // POLL_WAIT | gap timer between STATUS reads
    // POLL_RD   | STATUS read in flight
    // NEXT      | pick next entry, wrap, or finish
    // WR_STOP   | write CTRL=STOP after abort or bus error
    typedef enum logic [2:0] {
        IDLE, WR_PERIOD, WR_STEPS, WR_GO, POLL_WAIT, POLL_RD, NEXT, WR_STOP
    } state_t;

    localparam int              IW       = $clog2(DEPTH);
    localparam int              TW       = $clog2(POLL_GAP) + 1;
    localparam logic [IW:0]     DEPTH_C  = (IW+1)'(DEPTH);
    localparam logic [IW:0]     CNT_ONE  = 1;
    localparam logic [IW-1:0]   IDX_ONE  = 1;
    localparam logic [TW-1:0]   TMR_ONE  = 1;
    localparam logic [TW-1:0]   GAP_LOAD = TW'(POLL_GAP - 1);

    state_t          state_q, state_d;
    logic [IW:0]     count_q, count_d;
    logic [IW-1:0]   cur_idx_q, cur_idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            launched_q, launched_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic            abort_pend_q, abort_pend_d;
    logic            bus_error_q, bus_error_d;
    logic            seq_done_q, seq_done_d;
    logic [63:0]     table_q [DEPTH];
    logic            tbl_we;
    logic [63:0]     seg;
    logic            wr_state;
    logic            abort_now;
    logic            unused_rdata;

    assign seg       = table_q[cur_idx_q];
    assign wr_state  = (state_q == WR_PERIOD) || (state_q == WR_STEPS) ||
                       (state_q == WR_GO) || (state_q == WR_STOP);
    assign abort_now = abort_pend_q || abort;
    // Only the busy bit of STATUS matters; the rest of RDATA is intentionally ignored.
    assign unused_rdata = ^M_RDATA;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cur_idx_d    = cur_idx_q;
        timer_d      = timer_q;
        launched_d   = launched_q;
        awvalid_d    = awvalid_q && !M_AWREADY;
        wvalid_d     = wvalid_q && !M_WREADY;
        arvalid_d    = arvalid_q && !M_ARREADY;
        abort_pend_d = abort_pend_q || (abort && state_q != IDLE && state_q != WR_STOP);
        bus_error_d  = bus_error_q;
        seq_done_d   = 1'b0;
        tbl_we       = 1'b0;
        case (state_q)
            IDLE: begin
                abort_pend_d = 1'b0;
                if (abort) begin
                    count_d = '0;
                end else begin
                    if (cmd_valid && cmd_ready) begin
                        tbl_we  = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end
                    if (start && count_q != '0) begin
                        bus_error_d = 1'b0;
                        cur_idx_d   = '0;
                        state_d     = WR_PERIOD;
                    end
                end
            end
            WR_PERIOD, WR_STEPS, WR_GO: begin
                if (!launched_q) begin
                    if (abort_now) begin
                        state_d = WR_STOP;
                    end else if (state_q == WR_PERIOD && seg[31:0] == '0) begin
                        state_d = NEXT;
                    end else begin
                        launched_d = 1'b1;
                        awvalid_d  = 1'b1;
                        wvalid_d   = 1'b1;
                    end
                end else if (M_BVALID) begin
                    if (M_BRESP != 2'b00) begin
                        bus_error_d = 1'b1;
                        state_d     = WR_STOP;
                    end else if (abort_now) begin
                        state_d = WR_STOP;
                    end else if (state_q == WR_PERIOD) begin
                        state_d = WR_STEPS;
                    end else if (state_q == WR_STEPS) begin
                        state_d = WR_GO;
                    end else begin
                        state_d = POLL_WAIT;
                        timer_d = GAP_LOAD;
                    end
                end
            end
            WR_STOP: begin
                // The STOP write's own response is not checked; it always returns to IDLE.
                if (!launched_q) begin
                    launched_d = 1'b1;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                end else if (M_BVALID) begin
                    state_d = IDLE;
                end
            end
            POLL_WAIT: begin
                if (abort_now) begin
                    state_d = WR_STOP;
                end else if (timer_q == '0) begin
                    state_d   = POLL_RD;
                    arvalid_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            POLL_RD: begin
                if (M_RVALID) begin
                    if (M_RRESP != 2'b00) begin
                        bus_error_d = 1'b1;
                        state_d     = WR_STOP;
                    end else if (abort_now) begin
                        state_d = WR_STOP;
                    end else if (M_RDATA[BUSY_BIT]) begin
                        state_d = POLL_WAIT;
                        timer_d = GAP_LOAD;
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                if (abort_now) begin
                    state_d = WR_STOP;
                end else if ({1'b0, cur_idx_q} + CNT_ONE < count_q) begin
                    cur_idx_d = cur_idx_q + IDX_ONE;
                    state_d   = WR_PERIOD;
                end else if (loop_en) begin
                    cur_idx_d = '0;
                    state_d   = WR_PERIOD;
                end else begin
                    seq_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) launched_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            cur_idx_q    <= '0;
            timer_q      <= '0;
            launched_q   <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            bus_error_q  <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cur_idx_q    <= cur_idx_d;
            timer_q      <= timer_d;
            launched_q   <= launched_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            abort_pend_q <= abort_pend_d;
            bus_error_q  <= bus_error_d;
            seq_done_q   <= seq_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) table_q[count_q[IW-1:0]] <= cmd_data;
    end

    always_comb begin
        case (state_q)
            WR_PERIOD: M_AWADDR = REG_PERIOD;
            WR_STEPS:  M_AWADDR = REG_STEPS;
            default:   M_AWADDR = REG_CTRL;
        endcase
        case (state_q)
            WR_PERIOD: M_WDATA = {32'h0, seg[63:32]};
            WR_STEPS:  M_WDATA = {{32{seg[31]}}, seg[31:0]};
            WR_GO:     M_WDATA = 64'h1;
            default:   M_WDATA = 64'h0;
        endcase
    end

    assign cmd_ready = (state_q == IDLE) && (count_q < DEPTH_C);
    assign busy      = (state_q != IDLE);
    assign seq_done  = seq_done_q;
    assign bus_error = bus_error_q;
    assign cur_idx   = cur_idx_q;
    assign M_AWVALID = awvalid_q;
    assign M_AWPROT  = 3'b000;
    assign M_WVALID  = wvalid_q;
    assign M_WSTRB   = 8'hFF;
    assign M_BREADY  = wr_state;
    assign M_ARADDR  = REG_STATUS;
    assign M_ARVALID = arvalid_q;
    assign M_ARPROT  = 3'b000;
    assign M_RREADY  = (state_q == POLL_RD);
endmodule

// File: tb/tb_encoder_profile_sequencer.sv
// Bench for encoder_profile_sequencer: AXI-Lite slave model with configurable stalls and
// error injection; expected writes are queued per segment and checked as each write completes.
module tb_encoder_profile_sequencer;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 8;
    localparam int POLL_GAP = 16;
    localparam int IW       = 3;

    logic              clk, reset, cmd_valid, cmd_ready, start, abort, loop_en;
    logic              busy, seq_done, bus_error;
    logic [63:0]       cmd_data;
    logic [IW-1:0]     cur_idx;
    logic [ADDR_W-1:0] M_AWADDR, M_ARADDR;
    logic              M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic              M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [2:0]        M_AWPROT, M_ARPROT;
    logic [63:0]       M_WDATA, M_RDATA;
    logic [7:0]        M_WSTRB;
    logic [1:0]        M_BRESP, M_RRESP;

    typedef struct packed { logic [7:0] a; logic [63:0] d; } wr_t;
    wr_t           exp_q[$];
    wr_t           e_wr;
    logic [IW-1:0] idx_q[$];
    int total, bad;

    int  aw_dly, w_dly, ar_dly, busy_reads;
    bit  inj_en;
    logic [7:0] inj_addr;
    int  cyc, wr_cnt, ar_cnt, r_cnt, go_cnt, done_cnt, busy_left, last_ar;
    int  aw_wait, w_wait, ar_wait, aw_stall_max, dup_cnt, unstable_cnt, rise_bad, strb_bad, gap_bad, araddr_bad;
    bit  aw_have, w_have, ar_have, b_fire, r_fire, aw_prev;
    logic [7:0]  aw_a, aw_hold;
    logic [63:0] w_d;

    encoder_profile_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .start(start), .abort(abort), .loop_en(loop_en), .busy(busy), .seq_done(seq_done),
        .bus_error(bus_error), .cur_idx(cur_idx),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWPROT(M_AWPROT),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARPROT(M_ARPROT),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: decisions made on the falling edge, so a VALID&&READY seen here is the
    // handshake of the following rising edge. Responses are raised one cycle later.
    initial begin
        M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
        M_BRESP = 0; M_RRESP = 0; M_RDATA = 0;
        cyc = 0; aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0; aw_prev = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
                aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0; aw_prev = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (seq_done) done_cnt++;
                if (b_fire) begin M_BVALID = 0; b_fire = 0; end
                if (aw_have && w_have && !M_BVALID) begin
                    M_BRESP = (inj_en && aw_a == inj_addr) ? 2'b10 : 2'b00;
                    if (inj_en && aw_a == inj_addr) inj_en = 0;
                    M_BVALID = 1; aw_have = 0; w_have = 0; wr_cnt++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL wr_unexpected got addr=%h data=%h, required none", aw_a, w_d);
                    end else begin
                        e_wr = exp_q.pop_front();
                        if (aw_a !== e_wr.a || w_d !== e_wr.d) begin
                            bad++;
                            $display("FAIL wr_data got %h=%h required %h=%h", aw_a, w_d, e_wr.a, e_wr.d);
                        end
                    end
                    if (aw_a == 8'h10 && w_d == 64'h1) begin
                        busy_left = busy_reads; idx_q.push_back(cur_idx); go_cnt++;
                    end
                end
                if (M_BVALID && M_BREADY) b_fire = 1;

                if (r_fire) begin M_RVALID = 0; r_fire = 0; end
                if (ar_have && !M_RVALID) begin
                    M_RDATA = {63'h0, busy_left > 0};
                    if (busy_left > 0) busy_left--;
                    M_RRESP = 2'b00; M_RVALID = 1; ar_have = 0;
                end
                if (M_RVALID && M_RREADY && !r_fire) begin r_fire = 1; r_cnt++; end

                M_AWREADY = 0;
                if (M_AWVALID) begin
                    if (aw_have) dup_cnt++;
                    else begin
                        if (!aw_prev) begin
                            aw_hold = M_AWADDR;
                            if (!M_WVALID) rise_bad++;
                        end else if (M_AWADDR !== aw_hold) unstable_cnt++;
                        if (aw_wait >= aw_dly) begin
                            M_AWREADY = 1; aw_have = 1; aw_a = M_AWADDR;
                            if (aw_wait > aw_stall_max) aw_stall_max = aw_wait;
                            aw_wait = 0;
                        end else aw_wait++;
                    end
                end
                aw_prev = M_AWVALID && !M_AWREADY;

                M_WREADY = 0;
                if (M_WVALID) begin
                    if (w_have) dup_cnt++;
                    else begin
                        if (M_WSTRB !== 8'hFF) strb_bad++;
                        if (w_wait >= w_dly) begin
                            M_WREADY = 1; w_have = 1; w_d = M_WDATA; w_wait = 0;
                        end else w_wait++;
                    end
                end

                M_ARREADY = 0;
                if (M_ARVALID) begin
                    if (ar_have) dup_cnt++;
                    else if (ar_wait >= ar_dly) begin
                        M_ARREADY = 1; ar_have = 1; ar_wait = 0; ar_cnt++;
                        if (M_ARADDR !== 8'h18) araddr_bad++;
                        if (cyc - last_ar < POLL_GAP) gap_bad++;
                        last_ar = cyc;
                    end else ar_wait++;
                end
            end
        end
    end

    task automatic clear_obs();
        exp_q.delete(); idx_q.delete();
        wr_cnt = 0; ar_cnt = 0; r_cnt = 0; go_cnt = 0; done_cnt = 0; busy_left = 0; last_ar = -1000;
        aw_stall_max = 0; dup_cnt = 0; unstable_cnt = 0; rise_bad = 0; strb_bad = 0; gap_bad = 0;
        araddr_bad = 0; aw_dly = 0; w_dly = 0; ar_dly = 0; busy_reads = 0; inj_en = 0; inj_addr = 0;
    endtask

    task automatic clear_table();
        @(negedge clk); abort = 1;
        @(negedge clk); abort = 0;
        clear_obs();
    endtask

    task automatic load_seg(input logic [31:0] per, input logic [31:0] st);
        @(negedge clk); cmd_data = {per, st}; cmd_valid = 1;
        @(negedge clk); cmd_valid = 0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [63:0] d);
        e_wr.a = a; e_wr.d = d; exp_q.push_back(e_wr);
    endtask

    task automatic push_seg(input logic [31:0] per, input logic [31:0] st);
        push_wr(8'h00, {32'h0, per});
        push_wr(8'h08, {{32{st[31]}}, st});
        push_wr(8'h10, 64'h1);
    endtask

    task automatic run_seq(input int limit, output bit timed_out);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        timed_out = 1;
        for (int i = 0; i < limit; i++) begin
            if (!busy) begin timed_out = 0; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 0; cmd_valid = 0; cmd_data = 0; start = 0; abort = 0; loop_en = 0;
        clear_obs();
        repeat (3) @(negedge clk);
        total++; if ({busy, seq_done, bus_error} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b required 000", {busy, seq_done, bus_error}); end
        total++; if (cur_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got %0d required 0", cur_idx); end
        total++; if ({M_AWVALID, M_WVALID, M_ARVALID} !== 3'b000) begin bad++; $display("FAIL reset_valids got %b required 000", {M_AWVALID, M_WVALID, M_ARVALID}); end
        total++; if ({M_BREADY, M_RREADY} !== 2'b00) begin bad++; $display("FAIL reset_readys got %b required 00", {M_BREADY, M_RREADY}); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); end
        total++; if ({M_AWPROT, M_ARPROT} !== 6'd0) begin bad++; $display("FAIL reset_prot got %b required 0", {M_AWPROT, M_ARPROT}); end
        @(negedge clk); reset = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        clear_table();
        load_seg(32'd100, 32'd5);
        load_seg(32'd50, -32'sd3);
        push_wr(8'h00, 64'd100); push_wr(8'h08, 64'd5); push_wr(8'h10, 64'h1);
        push_wr(8'h00, 64'd50); push_wr(8'h08, 64'hFFFF_FFFF_FFFF_FFFD); push_wr(8'h10, 64'h1);
        busy_reads = 3;
        run_seq(2000, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout busy still 1 after bound, required 0"); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL basic_writes_left got %0d required 0", exp_q.size()); end
        total++; if (ar_cnt !== 8) begin bad++; $display("FAIL basic_ar_count got %0d required 8", ar_cnt); end
        total++; if (gap_bad !== 0 || araddr_bad !== 0) begin bad++; $display("FAIL basic_poll_gap got %0d/%0d required 0/0", gap_bad, araddr_bad); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_seq_done got %0d required 1", done_cnt); end
        total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL basic_bus_error got %b required 0", bus_error); end
        total++; if (idx_q.size() !== 2 || idx_q[0] !== 3'd0 || idx_q[1] !== 3'd1) begin bad++; $display("FAIL basic_idx got %p required '{0,1}", idx_q); end
    endtask

    task automatic test_aw_stall();
        bit to;
        clear_table();
        load_seg(32'd7, 32'd1);
        push_seg(32'd7, 32'd1);
        aw_dly = 5;
        run_seq(1000, to);
        total++; if (to) begin bad++; $display("FAIL stall_timeout busy still 1 after bound, required 0"); end
        total++; if (aw_stall_max !== 5) begin bad++; $display("FAIL stall_aw_cycles got %0d required 5", aw_stall_max); end
        total++; if (unstable_cnt !== 0 || rise_bad !== 0 || strb_bad !== 0) begin bad++; $display("FAIL stall_stability got %0d/%0d/%0d required 0/0/0", unstable_cnt, rise_bad, strb_bad); end
        total++; if (dup_cnt !== 0 || wr_cnt !== 3) begin bad++; $display("FAIL stall_dup got dup=%0d writes=%0d required 0/3", dup_cnt, wr_cnt); end
        total++; if (exp_q.size() !== 0 || done_cnt !== 1) begin bad++; $display("FAIL stall_result got left=%0d done=%0d required 0/1", exp_q.size(), done_cnt); end
    endtask

    task automatic test_bus_error();
        bit to;
        clear_table();
        load_seg(32'd20, 32'd4);
        push_wr(8'h00, 64'd20); push_wr(8'h08, 64'd4); push_wr(8'h10, 64'h0);
        inj_en = 1; inj_addr = 8'h08;
        run_seq(1000, to);
        total++; if (to) begin bad++; $display("FAIL err_timeout busy still 1 after bound, required 0"); end
        total++; if (bus_error !== 1'b1) begin bad++; $display("FAIL err_sticky got %b required 1", bus_error); end
        total++; if (exp_q.size() !== 0 || done_cnt !== 0 || ar_cnt !== 0) begin bad++; $display("FAIL err_flow got left=%0d done=%0d ar=%0d required 0/0/0", exp_q.size(), done_cnt, ar_cnt); end
        push_seg(32'd20, 32'd4);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        total++; if (bus_error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_clear got err=%b busy=%b required 0/1", bus_error, busy); end
        to = 1;
        for (int i = 0; i < 1000; i++) begin
            if (!busy) begin to = 0; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        total++; if (to || exp_q.size() !== 0 || done_cnt !== 1) begin bad++; $display("FAIL err_rerun got to=%0d left=%0d done=%0d required 0/0/1", to, exp_q.size(), done_cnt); end
    endtask

    task automatic test_loop_abort();
        bit to;
        clear_table();
        load_seg(32'd10, 32'd1);
        load_seg(32'd11, 32'd2);
        push_seg(32'd10, 32'd1); push_seg(32'd11, 32'd2);
        push_seg(32'd10, 32'd1); push_seg(32'd11, 32'd2);
        push_wr(8'h10, 64'h0);
        ar_dly = 3; loop_en = 1;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        to = 1;
        for (int i = 0; i < 2000; i++) begin
            if (go_cnt >= 4 && M_ARVALID) begin to = 0; break; end
            @(negedge clk);
        end
        abort = 1;
        @(negedge clk); abort = 0; loop_en = 0;
        total++; if (to) begin bad++; $display("FAIL loop_reach_poll no 4th poll within bound, required one"); end
        to = 1;
        for (int i = 0; i < 500; i++) begin
            if (!busy) begin to = 0; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        total++; if (to) begin bad++; $display("FAIL loop_abort_timeout busy still 1 after bound, required 0"); end
        total++; if (idx_q.size() !== 4 || idx_q[0] !== 3'd0 || idx_q[1] !== 3'd1 || idx_q[2] !== 3'd0 || idx_q[3] !== 3'd1) begin bad++; $display("FAIL loop_idx got %p required '{0,1,0,1}", idx_q); end
        total++; if (r_cnt !== ar_cnt || ar_cnt !== 4) begin bad++; $display("FAIL loop_r_done got ar=%0d r=%0d required 4/4", ar_cnt, r_cnt); end
        total++; if (exp_q.size() !== 0 || done_cnt !== 0) begin bad++; $display("FAIL loop_stop got left=%0d done=%0d required 0/0", exp_q.size(), done_cnt); end
    endtask

    task automatic test_full_zero();
        bit to;
        logic [31:0] st;
        clear_table();
        for (int i = 0; i < DEPTH; i++) begin
            st = (i == 2) ? 32'd0 : 32'(i + 1);
            load_seg(32'(10 + i), st);
            if (i != 2) push_seg(32'(10 + i), st);
        end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_cmd_ready got %b required 0", cmd_ready); end
        run_seq(5000, to);
        total++; if (to) begin bad++; $display("FAIL full_timeout busy still 1 after bound, required 0"); end
        total++; if (exp_q.size() !== 0 || wr_cnt !== 21 || ar_cnt !== 7) begin bad++; $display("FAIL full_zero_skip got left=%0d wr=%0d ar=%0d required 0/21/7", exp_q.size(), wr_cnt, ar_cnt); end
        total++; if (done_cnt !== 1 || idx_q.size() !== 7 || idx_q[2] !== 3'd3) begin bad++; $display("FAIL full_done got done=%0d idx=%p required 1, 7 entries skipping 2", done_cnt, idx_q); end
    endtask

    task automatic test_abort_idle();
        clear_table();
        load_seg(32'd3, 32'd3);
        @(negedge clk); abort = 1; start = 1;
        @(negedge clk); abort = 0; start = 0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_beats_start got busy=%b ready=%b required 0/1", busy, cmd_ready); end
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || wr_cnt !== 0) begin bad++; $display("FAIL empty_start got busy=%b wr=%0d required 0/0", busy, wr_cnt); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_table();
        load_seg(32'd5, 32'd1);
        aw_dly = 20;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        to = 1;
        for (int i = 0; i < 20; i++) begin
            if (M_AWVALID) begin to = 0; break; end
            @(negedge clk);
        end
        reset = 0;
        #1;
        total++; if (to || M_AWVALID !== 1'b0 || M_WVALID !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid got to=%0d aw=%b w=%b busy=%b required 0/0/0/0", to, M_AWVALID, M_WVALID, busy); end
        repeat (2) @(negedge clk);
        reset = 1;
        clear_obs();
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_basic();
        test_aw_stall();
        test_bus_error();
        test_loop_abort();
        test_full_zero();
        test_abort_idle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
